hram_cmd_seq: RTL and testbench
===============================

# hram_cmd_seq

Command sequencer that sits directly upstream of the HyperRAM transaction engines (register read, memory read, memory write). It accepts one user request at a time over a valid/ready handshake and packs the 48-bit command/address word. It pulses the start strobe of the matching engine, waits for that engine's end strobe, and enforces a chip-select recovery gap before it accepts the next request. It also drives the engine-select code that steers the shared pad mux.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before the request is aborted. Legal range 8..255.
- `RECOVER_CYCLES`, default 4: number of cycles spent in RECOVER after every transaction. Legal range 2..15.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a request is offered.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_reg`  in  1  1 = register space, 0 = memory space.
- `req_addr`  in  32  word address.
- `casig`  out  48  command/address word. It is registered and held stable from acceptance until the sequencer returns to IDLE.
- `sel`  out  2  active engine: 0 none, 1 rdreg, 2 rdmem, 3 wrmem.
- `rdreg_start`, `rdmem_start`, `wrmem_start`  out  1 each  one-cycle start pulses.
- `rdreg_end`, `rdmem_end`, `wrmem_end`  in  1 each  end strobes from the engines. Each may stay high for 2 cycles.
- `rsp_done`  out  1  one-cycle pulse when a transaction completes.
- `rsp_err`  out  1  one-cycle pulse when a request is rejected or aborted.
- `rsp_err_code`  out  2  1 = unsupported request, 2 = timeout. Valid while `rsp_err` is high.

## Operation
CA packing:
- `casig[47]` = ~`req_write`.
- `casig[46]` = `req_reg`.
- `casig[45]` = 1 (linear burst).
- `casig[44:16]` = `req_addr[31:3]`.
- `casig[15:3]` = 0.
- `casig[2:0]` = `req_addr[2:0]`.

Request mapping:
- Read + reg → rdreg.
- Read + mem → rdmem.
- Write + mem → wrmem.
- Write + reg is unsupported. It is accepted, not launched, and answered with error code 1.

States:
- IDLE: `req_ready`=1. On `req_valid`, latch `casig` and `sel`. Go to LAUNCH, or to RECOVER with the error pulse if the request is unsupported.
- LAUNCH: exactly one cycle. Assert the start pulse of the selected engine; `casig` is already valid in this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: increment the counter each cycle.
  - End strobe of the selected engine → `rsp_done`, go to RECOVER.
  - Counter reaches `TIMEOUT_CYCLES`-1 → `rsp_err` with code 2, go to RECOVER.
  - If the end strobe and the timeout occur in the same cycle, done wins.
  - End strobes from non-selected engines are ignored.
- RECOVER: `sel`=0 and no starts. Count `RECOVER_CYCLES`, then return to IDLE. This absorbs the second cycle of an end strobe and guarantees the CS# high gap.

Reset values:
- `req_ready`=0 until the first clock edge after reset release; the state is IDLE.
- `casig`=0, `sel`=0, all starts=0, `rsp_done`=0, `rsp_err`=0, `rsp_err_code`=0.

Reset during any state returns immediately to IDLE with all outputs at their reset values. No response is issued for the interrupted request.

## Timing
- Handshake: accept at edge T when `req_valid` && `req_ready`. The start pulse is high in cycle T+1 and `sel` is valid from T+1.
- Completion: if the end strobe is seen in cycle E, `rsp_done` is high in E+1 and `req_ready` returns in E+1+`RECOVER_CYCLES`.
- Timeout: `rsp_err` fires exactly `TIMEOUT_CYCLES` cycles after the start pulse.
- Rejection: `rsp_err` for an unsupported request is high in T+1, and `req_ready` returns `RECOVER_CYCLES` cycles later.
- Back-to-back requests: the minimum spacing between accepted requests is 3 + `RECOVER_CYCLES` + engine latency.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `hram_pkg` holds:
  - the FSM enum (IDLE, LAUNCH, WAIT, RECOVER);
  - the `sel` enum;
  - the error-code constants;
  - the CA bit-position constants;
  - a `pack_ca(write, reg, addr)` function.
- Single module, no sub-module. The counter is shared between WAIT and RECOVER.

## Test plan
- rdreg: read reg, addr 0x0000_0001 → `casig` = 0xE000_0000_0001, `rdreg_start` at T+1, `sel`=1. End strobe after 20 cycles → `rsp_done` once, then `req_ready` 4 cycles later.
- rdmem: read mem, addr 0x0012_345F → `casig[44:16]` = 0x2468B, `casig[2:0]` = 7, `casig[47:45]` = 3'b101, `rdmem_start`.
- wrmem: write mem, addr 0 → `casig` = 0x2000_0000_0000, `wrmem_start`. An end strobe held high for 2 cycles → exactly one `rsp_done`.
- Unsupported and timeout:
  - Write reg → no start pulse, `rsp_err` with code 1 at T+1.
  - Read mem with no end strobe → `rsp_err` with code 2 exactly 64 cycles after `rdmem_start`.
- Ignored strobe and reset: a stray `wrmem_end` during an rdreg WAIT is ignored. Reset asserted in WAIT → all outputs are 0 immediately, and IDLE/ready follow release.

Source files
------------

// File: rtl/hram_pkg.sv
// HyperRAM command sequencer shared types.
// FSM/select enums, error codes, CA layout and packer.
package hram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_RECOVER
   } state_t;

   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_RDREG = 2'd1,
      SEL_RDMEM = 2'd2,
      SEL_WRMEM = 2'd3
   } sel_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_UNSUP   = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam int CA_RW     = 47;
   localparam int CA_AS     = 46;
   localparam int CA_BURST  = 45;
   localparam int CA_ROW_HI = 44;
   localparam int CA_ROW_LO = 16;
   localparam int CA_COL_HI = 2;

   function automatic logic [47:0] pack_ca(
      input logic        write,
      input logic        reg_space,
      input logic [31:0] addr
   );
      logic [47:0] ca;
      ca = '0;
      ca[CA_RW]    = ~write;
      ca[CA_AS]    = reg_space;
      ca[CA_BURST] = 1'b1;
      ca[CA_ROW_HI:CA_ROW_LO] = addr[31:3];
      ca[CA_COL_HI:0] = addr[2:0];
      return ca;
   endfunction

endpackage

// File: rtl/hram_cmd_seq.sv
// HyperRAM command sequencer: accepts one request, packs CA,
// launches the matching engine and enforces a CS# recovery gap.
module hram_cmd_seq
   import hram_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int RECOVER_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_reg,
   input  logic [31:0] req_addr,
   output logic [47:0] casig,
   output logic [1:0]  sel,
   output logic        rdreg_start,
   output logic        rdmem_start,
   output logic        wrmem_start,
   input  logic        rdreg_end,
   input  logic        rdmem_end,
   input  logic        wrmem_end,
   output logic        rsp_done,
   output logic        rsp_err,
   output logic [1:0]  rsp_err_code
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] RC_LAST = 8'(RECOVER_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [47:0] ca_q, ca_d;
   sel_t        sel_q, sel_d;
   logic [2:0]  start_q, start_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic        ready_q, ready_d;
   logic        end_hit;

   // End strobe from the engine currently selected; others ignored.
   always_comb begin
      end_hit = 1'b0;
      unique case (sel_q)
         SEL_RDREG: end_hit = rdreg_end;
         SEL_RDMEM: end_hit = rdmem_end;
         SEL_WRMEM: end_hit = wrmem_end;
         default:   end_hit = 1'b0;
      endcase
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ca_d    = ca_q;
      sel_d   = sel_q;
      start_d = 3'b000;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      ready_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && ready_q) begin
               ca_d  = pack_ca(req_write, req_reg, req_addr);
               cnt_d = '0;
               if (req_write && req_reg) begin
                  sel_d   = SEL_NONE;
                  err_d   = 1'b1;
                  code_d  = ERR_UNSUP;
                  state_d = ST_RECOVER;
               end else begin
                  unique case (1'b1)
                     req_reg: begin
                        sel_d      = SEL_RDREG;
                        start_d[0] = 1'b1;
                     end
                     req_write: begin
                        sel_d      = SEL_WRMEM;
                        start_d[2] = 1'b1;
                     end
                     default: begin
                        sel_d      = SEL_RDMEM;
                        start_d[1] = 1'b1;
                     end
                  endcase
                  state_d = ST_LAUNCH;
               end
            end else begin
               ready_d = 1'b1;
            end
         end
         ST_LAUNCH: begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (end_hit) begin
               done_d  = 1'b1;
               sel_d   = SEL_NONE;
               cnt_d   = '0;
               state_d = ST_RECOVER;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
               sel_d   = SEL_NONE;
               cnt_d   = '0;
               state_d = ST_RECOVER;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_RECOVER: begin
            if (cnt_q == RC_LAST) begin
               ready_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ca_q    <= '0;
         sel_q   <= SEL_NONE;
         start_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ca_q    <= ca_d;
         sel_q   <= sel_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         ready_q <= ready_d;
      end
   end

   assign req_ready    = ready_q;
   assign casig        = ca_q;
   assign sel          = sel_q;
   assign rdreg_start  = start_q[0];
   assign rdmem_start  = start_q[1];
   assign wrmem_start  = start_q[2];
   assign rsp_done     = done_q;
   assign rsp_err      = err_q;
   assign rsp_err_code = code_q;

endmodule

// File: tb/tb_hram_cmd_seq.sv
// Self-checking bench for hram_cmd_seq: timeline model
// derived from request kind, strobe delay and timeout.
module tb_hram_cmd_seq;

   localparam int TO = 64;
   localparam int RC = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_reg;
   logic [31:0] req_addr;
   logic [47:0] casig;
   logic [1:0]  sel;
   logic        rdreg_start;
   logic        rdmem_start;
   logic        wrmem_start;
   logic        rdreg_end;
   logic        rdmem_end;
   logic        wrmem_end;
   logic        rsp_done;
   logic        rsp_err;
   logic [1:0]  rsp_err_code;

   int checks = 0;
   int errors = 0;

   hram_cmd_seq #(
      .TIMEOUT_CYCLES(TO),
      .RECOVER_CYCLES(RC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_reg(req_reg),
      .req_addr(req_addr),
      .casig(casig),
      .sel(sel),
      .rdreg_start(rdreg_start),
      .rdmem_start(rdmem_start),
      .wrmem_start(wrmem_start),
      .rdreg_end(rdreg_end),
      .rdmem_end(rdmem_end),
      .wrmem_end(wrmem_end),
      .rsp_done(rsp_done),
      .rsp_err(rsp_err),
      .rsp_err_code(rsp_err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] obs,
                      input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_casig"}, casig, 48'h0);
      chk({tag, "_sel"}, 48'(sel), 48'h0);
      chk({tag, "_starts"},
          48'({rdreg_start, rdmem_start, wrmem_start}), 48'h0);
      chk({tag, "_done"}, 48'(rsp_done), 48'h0);
      chk({tag, "_err"}, 48'(rsp_err), 48'h0);
      chk({tag, "_code"}, 48'(rsp_err_code), 48'h0);
      chk({tag, "_ready"}, 48'(req_ready), 48'h0);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 48'(req_ready), 48'h1);
   endtask

   // d: end strobe d cycles after the start pulse (<0: never).
   task automatic run_txn(input logic w, input logic r,
                          input logic [31:0] a, input int d,
                          input int len, input bit stray,
                          input bit use_lit, input logic [47:0] lit);
      int eng, e, rr;
      bit ended, in_end;
      logic [47:0] ca;
      eng = (w && r) ? 0 : (r ? 1 : (w ? 3 : 2));
      ca = {~w, r, 1'b1, a[31:3], 13'b0, a[2:0]};
      ended = (eng != 0) && (d >= 1) && (1 + d <= TO);
      e = 1 + d;
      rr = (eng == 0) ? 1 : (ended ? e + 1 : TO + 1);
      wait_ready();
      req_valid = 1'b1;
      req_write = w;
      req_reg = r;
      req_addr = a;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_reg = 1'($urandom);
      req_addr = $urandom;
      for (int k = 1; k <= rr + RC; k++) begin
         if (k > 1) @(negedge clk);
         chk("rdreg_start", 48'(rdreg_start), 48'(k == 1 && eng == 1));
         chk("rdmem_start", 48'(rdmem_start), 48'(k == 1 && eng == 2));
         chk("wrmem_start", 48'(wrmem_start), 48'(k == 1 && eng == 3));
         chk("sel", 48'(sel), 48'((eng != 0 && k < rr) ? eng : 0));
         chk("done", 48'(rsp_done), 48'(ended && k == rr));
         chk("err", 48'(rsp_err), 48'(!ended && k == rr));
         chk("err_code", 48'(rsp_err_code),
             48'((!ended && k == rr) ? ((eng == 0) ? 1 : 2) : 0));
         chk("ready", 48'(req_ready), 48'(k >= rr + RC));
         chk("casig", casig, ca);
         if (k == 1 && use_lit) chk("casig_lit", casig, lit);
         in_end = ended && k >= e && k < e + len;
         rdreg_end = (eng == 1 && in_end) ||
                     (stray && eng != 1 && eng != 0 && k >= 2 &&
                      k < rr && $urandom_range(0, 2) == 0);
         rdmem_end = (eng == 2 && in_end) ||
                     (stray && eng != 2 && eng != 0 && k >= 2 &&
                      k < rr && $urandom_range(0, 2) == 0);
         wrmem_end = (eng == 3 && in_end) ||
                     (stray && eng != 3 && eng != 0 && k >= 2 &&
                      k < rr && $urandom_range(0, 2) == 0);
      end
      rdreg_end = 1'b0;
      rdmem_end = 1'b0;
      wrmem_end = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_reg = 1'b0;
      req_addr = '0;
      rdreg_end = 1'b0;
      rdmem_end = 1'b0;
      wrmem_end = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_zero("rst");
      rst = 1'b1;
      req_valid = 1'b1;
      #1;
      chk("ready_pre_edge", 48'(req_ready), 48'h0);
      @(negedge clk);
      chk("ready_post_edge", 48'(req_ready), 48'h1);
      chk("no_accept_unready", 48'(sel), 48'h0);
      req_valid = 1'b0;

      run_txn(1'b0, 1'b1, 32'h0000_0001, 20, 1, 1'b1,
              1'b1, 48'hE000_0000_0001);
      run_txn(1'b0, 1'b0, 32'h0012_345F, 7, 1, 1'b0,
              1'b1, 48'hA002_468B_0007);
      run_txn(1'b1, 1'b0, 32'h0000_0000, 5, 2, 1'b0,
              1'b1, 48'h2000_0000_0000);
      run_txn(1'b1, 1'b1, 32'hDEAD_BEEF, 3, 1, 1'b0, 1'b0, '0);
      run_txn(1'b0, 1'b0, 32'h0000_1000, -1, 1, 1'b1, 1'b0, '0);
      run_txn(1'b0, 1'b1, 32'h0000_0040, TO - 1, 2, 1'b0, 1'b0, '0);
      run_txn(1'b1, 1'b0, 32'h0000_0008, 1, 2, 1'b1, 1'b0, '0);

      for (int i = 0; i < 16; i++) begin
         int d;
         case ($urandom_range(0, 5))
            0: d = -1;
            1: d = TO - 1;
            2: d = 1;
            default: d = $urandom_range(1, 30);
         endcase
         run_txn(1'($urandom), 1'($urandom), $urandom, d,
                 $urandom_range(1, 2), 1'($urandom), 1'b0, '0);
      end

      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_reg = 1'b1;
      req_addr = 32'h0ABC_DEF5;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_sel", 48'(sel), 48'h1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_idle_zero("rst_wait");
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_ready_pre", 48'(req_ready), 48'h0);
      @(negedge clk);
      chk("rel_ready", 48'(req_ready), 48'h1);
      for (int k = 0; k < 6; k++) begin
         rdreg_end = (k < 2);
         @(negedge clk);
         chk("rel_no_rsp", 48'({rsp_done, rsp_err}), 48'h0);
      end
      rdreg_end = 1'b0;

      run_txn(1'b0, 1'b0, 32'h0000_0123, 4, 1, 1'b0, 1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
